// File: rtl/cnt_dec_pkg.sv
// Shared types and constants for the counter sequence decoder.
// Holds the decoder FSM states, the step class codes and the width of the
// optional statistics counters (enabled with CNT_DEC_STATS_EN).
package cnt_dec_pkg;

   // Decoder FSM states
   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_STOP  = 2'b01,
      S_UP    = 2'b10,
      S_DOWN  = 2'b11
   } state_e;

   // Step class codes, also the encoding driven on the cls output
   typedef enum logic [1:0] {
      CLS_HOLD = 2'b00,
      CLS_UP   = 2'b01,
      CLS_DOWN = 2'b10,
      CLS_LOAD = 2'b11
   } cls_e;

   // Width of the saturating load/wrap statistics counters
   localparam int STATS_W = 16;

endpackage

// File: rtl/cnt_dec_classify.sv
// Combinational step classifier for the counter sequence decoder.
// Compares a new sample against the previous one (mod 2^WIDTH) and reports
// whether the counter held, stepped up, stepped down or was loaded, plus a
// flag when the step crossed the max/zero boundary.
module cnt_dec_classify
   import cnt_dec_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0] s_i,
   output cls_e             cls_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] pPlus;
   logic [WIDTH-1:0] pMinus;

   assign pPlus  = p_i + WIDTH'(1);
   assign pMinus = p_i - WIDTH'(1);

   // Priority classification: equality first, then +1, then -1, else a load.
   // A load landing exactly on p+1 or p-1 cannot be told apart from a step.
   always_comb begin
      cls_o  = CLS_LOAD;
      wrap_o = 1'b0;
      if (s_i == p_i) begin
         cls_o = CLS_HOLD;
      end else if (s_i == pPlus) begin
         cls_o  = CLS_UP;
         wrap_o = (p_i == {WIDTH{1'b1}});
      end else if (s_i == pMinus) begin
         cls_o  = CLS_DOWN;
         wrap_o = (p_i == {WIDTH{1'b0}});
      end
   end

endmodule

// File: rtl/cnt_seq_decoder.sv
// Counter sequence decoder top level.
// Watches the sampled output of an up/down/load counter and recovers the
// control behaviour behind it: direction, wrap-around, parallel loads and
// the length of the current run of steps. All outputs are registered.
// Optional feature macro: CNT_DEC_STATS_EN adds saturating load_cnt and
// wrap_cnt counters; without it those ports do not exist.
module cnt_seq_decoder
   import cnt_dec_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int RUN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [WIDTH-1:0] cnt,
   input  logic             clr,
   output logic             cls_valid,
   output logic [1:0]       cls,
   output logic             dir_o,
   output logic             moving_o,
   output logic             wrap_o,
   output logic             load_o,
   output logic [WIDTH-1:0] load_data,
   output logic [RUN_W-1:0] run_len
`ifdef CNT_DEC_STATS_EN
  ,output logic [STATS_W-1:0] load_cnt,
   output logic [STATS_W-1:0] wrap_cnt
`endif
);

   state_e           state_q;
   logic [WIDTH-1:0] prev_q;
   cls_e             cls_q;
   logic             dir_q;
   logic [RUN_W-1:0] runLen_q;
   logic [RUN_W-1:0] runLen_d;
   logic [WIDTH-1:0] loadData_q;
   logic             clsValid_q;
   logic             wrap_q;
   logic             load_q;

   cls_e             stepCls;
   logic             stepWrap;

   cnt_dec_classify #(
      .WIDTH (WIDTH)
   ) uClassify (
      .p_i    (prev_q),
      .s_i    (cnt),
      .cls_o  (stepCls),
      .wrap_o (stepWrap)
   );

   // Next run length for a classified step: restart at 1 on a change of
   // direction (or leaving a stop), count up saturating while the
   // direction repeats, and fall to 0 on HOLD or LOAD
   always_comb begin
      runLen_d = '0;
      if (stepCls == CLS_UP) begin
         if (state_q == S_UP) begin
            runLen_d = (runLen_q == {RUN_W{1'b1}}) ? runLen_q : runLen_q + RUN_W'(1);
         end else begin
            runLen_d = RUN_W'(1);
         end
      end else if (stepCls == CLS_DOWN) begin
         if (state_q == S_DOWN) begin
            runLen_d = (runLen_q == {RUN_W{1'b1}}) ? runLen_q : runLen_q + RUN_W'(1);
         end else begin
            runLen_d = RUN_W'(1);
         end
      end
   end

   // Decoder FSM with its registered outputs: the first sample after reset
   // or clear only seeds prev, every later sample is classified and pulses
   // cls_valid; clear beats a simultaneous sample and discards it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         prev_q     <= '0;
         cls_q      <= CLS_HOLD;
         dir_q      <= 1'b1;
         runLen_q   <= '0;
         loadData_q <= '0;
         clsValid_q <= 1'b0;
         wrap_q     <= 1'b0;
         load_q     <= 1'b0;
      end else begin
         clsValid_q <= 1'b0;
         wrap_q     <= 1'b0;
         load_q     <= 1'b0;
         if (clr) begin
            state_q  <= S_EMPTY;
            runLen_q <= '0;
         end else if (valid) begin
            prev_q <= cnt;
            if (state_q == S_EMPTY) begin
               state_q <= S_STOP;
            end else begin
               clsValid_q <= 1'b1;
               cls_q      <= stepCls;
               wrap_q     <= stepWrap;
               runLen_q   <= runLen_d;
               unique case (stepCls)
                  CLS_HOLD: begin
                     state_q <= S_STOP;
                  end
                  CLS_UP: begin
                     state_q <= S_UP;
                     dir_q   <= 1'b1;
                  end
                  CLS_DOWN: begin
                     state_q <= S_DOWN;
                     dir_q   <= 1'b0;
                  end
                  CLS_LOAD: begin
                     state_q    <= S_STOP;
                     load_q     <= 1'b1;
                     loadData_q <= cnt;
                  end
               endcase
            end
         end
      end
   end

   assign cls_valid = clsValid_q;
   assign cls       = cls_q;
   assign dir_o     = dir_q;
   assign moving_o  = (state_q == S_UP) || (state_q == S_DOWN);
   assign wrap_o    = wrap_q;
   assign load_o    = load_q;
   assign load_data = loadData_q;
   assign run_len   = runLen_q;

`ifdef CNT_DEC_STATS_EN
   logic [STATS_W-1:0] loadCnt_q;
   logic [STATS_W-1:0] wrapCnt_q;
   logic               stepTaken;

   assign stepTaken = !clr && valid && (state_q != S_EMPTY);

   // Saturating event counters, bumped on the same edge that raises the
   // matching pulse so they always include the pulse currently on display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loadCnt_q <= '0;
         wrapCnt_q <= '0;
      end else if (clr) begin
         loadCnt_q <= '0;
         wrapCnt_q <= '0;
      end else if (stepTaken) begin
         if ((stepCls == CLS_LOAD) && (loadCnt_q != {STATS_W{1'b1}})) begin
            loadCnt_q <= loadCnt_q + STATS_W'(1);
         end
         if (stepWrap && (wrapCnt_q != {STATS_W{1'b1}})) begin
            wrapCnt_q <= wrapCnt_q + STATS_W'(1);
         end
      end
   end

   assign load_cnt = loadCnt_q;
   assign wrap_cnt = wrapCnt_q;
`endif

endmodule

// File: tb/tb_cnt_seq_decoder.sv
// Self-checking bench for cnt_seq_decoder (WIDTH=4, RUN_W=8).
// Directed samples push their hand-computed decoded result into a
// scoreboard queue; an independent monitor pops one entry per cls_valid
// pulse and compares every output field.
module tb_cnt_seq_decoder;

   logic       clk;
   logic       rst;
   logic       valid;
   logic [3:0] cnt;
   logic       clr;
   logic       cls_valid;
   logic [1:0] cls;
   logic       dir_o;
   logic       moving_o;
   logic       wrap_o;
   logic       load_o;
   logic [3:0] load_data;
   logic [7:0] run_len;
`ifdef CNT_DEC_STATS_EN
   logic [15:0] load_cnt;
   logic [15:0] wrap_cnt;
`endif

   localparam logic [1:0] C_HOLD = 2'b00;
   localparam logic [1:0] C_UP   = 2'b01;
   localparam logic [1:0] C_DOWN = 2'b10;
   localparam logic [1:0] C_LOAD = 2'b11;

   typedef struct {
      logic [1:0] cls;
      logic       dir;
      logic       moving;
      logic       wrap;
      logic       load;
      logic [3:0] loadData;
      logic [7:0] runLen;
   } exp_t;

   exp_t sbQ[$];
   exp_t monItem;
   int   vecCount  = 0;
   int   missCount = 0;

   cnt_seq_decoder #(
      .WIDTH (4),
      .RUN_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .cnt       (cnt),
      .clr       (clr),
      .cls_valid (cls_valid),
      .cls       (cls),
      .dir_o     (dir_o),
      .moving_o  (moving_o),
      .wrap_o    (wrap_o),
      .load_o    (load_o),
      .load_data (load_data),
      .run_len   (run_len)
`ifdef CNT_DEC_STATS_EN
     ,.load_cnt  (load_cnt),
      .wrap_cnt  (wrap_cnt)
`endif
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One counted comparison, printing a FAIL line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive one sample for one clock; queue its expected result when it should pulse
   task automatic applyStimulus(input logic [3:0] s, input bit pulse, input logic [1:0] c,
                                input logic d, input logic m, input logic w, input logic l,
                                input logic [3:0] ld, input logic [7:0] rl);
      exp_t e;
      valid = 1'b1;
      cnt   = s;
      if (pulse) begin
         e.cls = c; e.dir = d; e.moving = m; e.wrap = w;
         e.load = l; e.loadData = ld; e.runLen = rl;
         sbQ.push_back(e);
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   // Wait (bounded) for the monitor to consume all queued expectations
   task automatic drainCheck(input string name);
      for (int i = 0; i < 8 && sbQ.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      checkOutput(name, sbQ.size(), 0);
   endtask

   // Compare every output against its reset value
   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_cls"},       cls,       0);
      checkOutput({tag, "_dir"},       dir_o,     1);
      checkOutput({tag, "_moving"},    moving_o,  0);
      checkOutput({tag, "_run_len"},   run_len,   0);
      checkOutput({tag, "_load_data"}, load_data, 0);
      checkOutput({tag, "_cls_valid"}, cls_valid, 0);
      checkOutput({tag, "_wrap"},      wrap_o,    0);
      checkOutput({tag, "_load"},      load_o,    0);
`ifdef CNT_DEC_STATS_EN
      checkOutput({tag, "_load_cnt"},  load_cnt,  0);
      checkOutput({tag, "_wrap_cnt"},  wrap_cnt,  0);
`endif
   endtask

   // Monitor: every cls_valid pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (!rst && cls_valid) begin
         if (sbQ.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL unexpected_pulse: got cls=%0d with no expectation queued (t=%0t)", cls, $time);
         end else begin
            monItem = sbQ.pop_front();
            checkOutput("sb_cls",       cls,       monItem.cls);
            checkOutput("sb_dir",       dir_o,     monItem.dir);
            checkOutput("sb_moving",    moving_o,  monItem.moving);
            checkOutput("sb_wrap",      wrap_o,    monItem.wrap);
            checkOutput("sb_load",      load_o,    monItem.load);
            checkOutput("sb_load_data", load_data, monItem.loadData);
            checkOutput("sb_run_len",   run_len,   monItem.runLen);
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence
   initial begin
      int s;
      int p;
      int rl;
      rst   = 1'b1;
      valid = 1'b0;
      clr   = 1'b0;
      cnt   = '0;
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Counting up from 3: first sample seeds, then two UP steps
      applyStimulus(4'd3,  0, C_HOLD, 1, 0, 0, 0, 4'd0,  8'd0);
      applyStimulus(4'd4,  1, C_UP,   1, 1, 0, 0, 4'd0,  8'd1);
      applyStimulus(4'd5,  1, C_UP,   1, 1, 0, 0, 4'd0,  8'd2);
      // Jump to 14 is a load, then wrap upward through 15->0
      applyStimulus(4'd14, 1, C_LOAD, 1, 0, 0, 1, 4'd14, 8'd0);
      applyStimulus(4'd15, 1, C_UP,   1, 1, 0, 0, 4'd14, 8'd1);
      applyStimulus(4'd0,  1, C_UP,   1, 1, 1, 0, 4'd14, 8'd2);
      applyStimulus(4'd1,  1, C_UP,   1, 1, 0, 0, 4'd14, 8'd3);
      // Count down through 0->15
      applyStimulus(4'd2,  1, C_UP,   1, 1, 0, 0, 4'd14, 8'd4);
      applyStimulus(4'd1,  1, C_DOWN, 0, 1, 0, 0, 4'd14, 8'd1);
      applyStimulus(4'd0,  1, C_DOWN, 0, 1, 0, 0, 4'd14, 8'd2);
      applyStimulus(4'd15, 1, C_DOWN, 0, 1, 1, 0, 4'd14, 8'd3);
      // Load, hold, load
      applyStimulus(4'd5,  1, C_LOAD, 0, 0, 0, 1, 4'd5,  8'd0);
      applyStimulus(4'd5,  1, C_HOLD, 0, 0, 0, 0, 4'd5,  8'd0);
      applyStimulus(4'd12, 1, C_LOAD, 0, 0, 0, 1, 4'd12, 8'd0);
      drainCheck("drain_basic");
`ifdef CNT_DEC_STATS_EN
      checkOutput("stats_load_cnt", load_cnt, 3);
      checkOutput("stats_wrap_cnt", wrap_cnt, 2);
`endif

      // Clear together with a sample: sample dropped, history partly kept
      @(posedge clk);
      #1;
      clr   = 1'b1;
      valid = 1'b1;
      cnt   = 4'd9;
      @(posedge clk);
      #1;
      clr   = 1'b0;
      valid = 1'b0;
      checkOutput("clr_run_len",   run_len,   0);
      checkOutput("clr_moving",    moving_o,  0);
      checkOutput("clr_dir_kept",  dir_o,     0);
      checkOutput("clr_load_data", load_data, 12);
`ifdef CNT_DEC_STATS_EN
      checkOutput("clr_load_cnt",  load_cnt,  0);
      checkOutput("clr_wrap_cnt",  wrap_cnt,  0);
`endif
      applyStimulus(4'd10, 0, C_HOLD, 0, 0, 0, 0, 4'd12, 8'd0);
      applyStimulus(4'd11, 1, C_UP,   1, 1, 0, 0, 4'd12, 8'd1);
      drainCheck("drain_clr");

      // Asynchronous reset mid-cycle: outputs fall back before any edge
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkResetValues("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(4'd7,  0, C_HOLD, 1, 0, 0, 0, 4'd0,  8'd0);
      applyStimulus(4'd8,  1, C_UP,   1, 1, 0, 0, 4'd0,  8'd1);

      // Long upward run to reach run_len saturation at 255
      for (int j = 1; j <= 260; j++) begin
         s  = (8 + j) % 16;
         p  = (7 + j) % 16;
         rl = (1 + j > 255) ? 255 : 1 + j;
         applyStimulus(4'(s), 1, C_UP, 1, 1, (p == 15), 0, 4'd0, 8'(rl));
      end
      drainCheck("drain_sat");
      checkOutput("sat_run_len_hold", run_len, 255);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
